dmem_arbiter: RTL and testbench

//  Shares the single-port synchronous data RAM (Pipedmem-style: 1 write OR 1 read per clka edge,

---
 rtl/dmem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Shares one single-port synchronous data RAM between the CPU MEM
//             stage (m0, high priority) and a debug/DMA loader port (m1).
//             At most one RAM access is issued per cycle. Each read is tagged
//             with its owner, so the returned data reaches the right port.
//             Out-of-range accesses are granted but have no effect on the RAM.
//  Options  : ARB_RR_EN - round-robin arbitration instead of fixed priority
//             plus starvation counter.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 8,   // denied m1 cycles before m1 is forced to win (1..255)
  parameter int unsigned RAM_DEPTH  = 6    // log2 of RAM words
) (
  input  logic        clka,
  input  logic        rst,
  // requester 0: CPU MEM stage
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  // requester 1: debug / DMA loader
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  // RAM side
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        addr_err
);

  // Byte range compared in 64 bits so that large RAM_DEPTH values cannot wrap.
  localparam logic [63:0] BYTE_RANGE = 64'd4 << RAM_DEPTH;

  logic        w_m1_wins;
  logic        w_gnt_any;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_din;
  logic        w_sel_oob;
  logic        w_rd_issue;

  logic        rd_pend_q,  rd_pend_d;
  logic        rd_owner_q, rd_owner_d;   // 0 = m0, 1 = m1
  logic        rd_oob_q,   rd_oob_d;
  logic        addr_err_q, addr_err_d;

`ifdef ARB_RR_EN
  // rr_last remembers the most recent winner (0 = m0, 1 = m1).
  logic rr_last_q, rr_last_d;

  // When both request, the port that did not win last time goes first.
  always_comb begin
    w_m1_wins = m1_req && (!m0_req || !rr_last_q);
  end

  // Track the most recent winner; reset value makes m0 win the first tie.
  always_comb begin
    rr_last_d = rr_last_q;
    if (m0_gnt) begin
      rr_last_d = 1'b0;
    end else if (m1_gnt) begin
      rr_last_d = 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clka) begin
    if (rst) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`else
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0] starve_q, starve_d;

  // Fixed priority m0 > m1, overridden once m1 has been denied long enough.
  always_comb begin
    w_m1_wins = m1_req && (!m0_req || (starve_q == STARVE_LIM));
  end

  // Count consecutive denied m1 cycles, saturating at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!m1_req || m1_gnt) begin
      starve_d = 8'd0;
    end else if (starve_q < STARVE_LIM) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clka) begin
    if (rst) begin
      starve_q <= 8'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // Grants are combinational and suppressed entirely while in reset.
  always_comb begin
    m1_gnt = !rst && w_m1_wins;
    m0_gnt = !rst && m0_req && !w_m1_wins;
  end

  // Steer the winning requester onto the RAM port; idle bus is all zeros.
  always_comb begin
    w_gnt_any  = m0_gnt || m1_gnt;
    w_sel_we   = 1'b0;
    w_sel_addr = 32'd0;
    w_sel_din  = 32'd0;
    if (m0_gnt) begin
      w_sel_we   = m0_we;
      w_sel_addr = m0_addr;
      w_sel_din  = m0_wdata;
    end else if (m1_gnt) begin
      w_sel_we   = m1_we;
      w_sel_addr = m1_addr;
      w_sel_din  = m1_wdata;
    end
    w_sel_oob  = w_gnt_any && ({32'd0, w_sel_addr} >= BYTE_RANGE);
    w_rd_issue = w_gnt_any && !w_sel_we;
  end

  // Out-of-range writes must never reach the RAM.
  always_comb begin
    mem_we   = w_sel_we && !w_sel_oob;
    mem_addr = w_sel_addr;
    mem_din  = w_sel_din;
  end

  // Next-state for the read tag and the error pulse.
  always_comb begin
    rd_pend_d  = w_rd_issue;
    rd_owner_d = rd_owner_q;
    rd_oob_d   = rd_oob_q;
    if (w_rd_issue) begin
      rd_owner_d = m1_gnt;
      rd_oob_d   = w_sel_oob;
    end
    addr_err_d = w_sel_oob;
  end

  // Read tag and error registers; a pending read is dropped on reset.
  always_ff @(posedge clka) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      rd_oob_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rd_oob_q   <= rd_oob_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Route the returned word to its owner; out-of-range reads return zero.
  // Outputs are held quiet during reset so a read issued just before reset
  // never shows up.
  always_comb begin
    m0_rvalid = !rst && rd_pend_q && !rd_owner_q;
    m1_rvalid = !rst && rd_pend_q &&  rd_owner_q;
    m0_rdata  = (m0_rvalid && !rd_oob_q) ? mem_dout : 32'd0;
    m1_rdata  = (m1_rvalid && !rd_oob_q) ? mem_dout : 32'd0;
    addr_err  = !rst && addr_err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Self-checking bench for dmem_arbiter. A synchronous RAM model
//             sits on the memory port; a behavioural reference (golden word
//             array plus a queue of expected read returns) predicts every
//             output each cycle. Directed scenarios pin literal values,
//             followed by a randomized phase.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int STARVE_MAX = 8;
  localparam int RAM_DEPTH  = 6;
  localparam int WORDS      = 1 << RAM_DEPTH;
  localparam logic [31:0] BYTES = 32'(4 * WORDS);

  logic        clka = 1'b0;
  logic        rst  = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = 32'd0, m1_wdata = 32'd0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        addr_err;

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter #(.STARVE_MAX(STARVE_MAX), .RAM_DEPTH(RAM_DEPTH)) dut (
    .clka(clka), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .addr_err(addr_err)
  );

  always #5 clka = ~clka;

  // RAM on the memory port: one access per edge, read data one cycle later.
  logic [31:0] ram [0:WORDS-1];
  always @(posedge clka) begin
    if (mem_we) ram[mem_addr[RAM_DEPTH+1:2]] <= mem_din;
    mem_dout <= ram[mem_addr[RAM_DEPTH+1:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %08h expected %08h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference ----------------
  typedef struct { bit owner; logic [31:0] data; } rd_t;
  rd_t         pq[$];
  logic [31:0] gold [0:WORDS-1];
  int          starve  = 0;
  bit          rr_last = 1'b1;
  bit          err_prev = 1'b0;

  bit          e0g, e1g, w1, ewe, eoob, ev0, ev1;
  logic [31:0] eaddr, edin, ed0, ed1;
  bit          ereq_we;
  rd_t         ent;

  always @(negedge clka) begin
    e0g = 1'b0; e1g = 1'b0;
    if (!rst) begin
`ifdef ARB_RR_EN
      w1 = m1_req && (!m0_req || !rr_last);
`else
      w1 = m1_req && (!m0_req || starve == STARVE_MAX);
`endif
      e1g = w1;
      e0g = m0_req && !w1;
    end
    eaddr   = e0g ? m0_addr  : (e1g ? m1_addr  : 32'd0);
    edin    = e0g ? m0_wdata : (e1g ? m1_wdata : 32'd0);
    ereq_we = e0g ? m0_we    : (e1g ? m1_we    : 1'b0);
    eoob    = (e0g || e1g) && (eaddr >= BYTES);
    ewe     = ereq_we && !eoob;

    ev0 = 1'b0; ev1 = 1'b0; ed0 = 32'd0; ed1 = 32'd0;
    if (!rst && pq.size() > 0) begin
      ent = pq[0];
      if (ent.owner) begin ev1 = 1'b1; ed1 = ent.data; end
      else           begin ev0 = 1'b1; ed0 = ent.data; end
    end

    chk("m0_gnt",    {31'd0, m0_gnt},    {31'd0, e0g});
    chk("m1_gnt",    {31'd0, m1_gnt},    {31'd0, e1g});
    chk("mem_we",    {31'd0, mem_we},    {31'd0, ewe});
    chk("mem_addr",  mem_addr,           eaddr);
    chk("mem_din",   mem_din,            edin);
    chk("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, ev0});
    chk("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, ev1});
    chk("m0_rdata",  m0_rdata,           ed0);
    chk("m1_rdata",  m1_rdata,           ed1);
    chk("addr_err",  {31'd0, addr_err},  {31'd0, (!rst && err_prev)});

    // advance the reference to the next cycle
    pq.delete();
    if ((e0g || e1g) && !ereq_we) begin
      ent.owner = e1g;
      ent.data  = eoob ? 32'd0 : gold[eaddr[RAM_DEPTH+1:2]];
      pq.push_back(ent);
    end
    if (ewe) gold[eaddr[RAM_DEPTH+1:2]] = edin;
    err_prev = eoob && !rst;
    if (rst || !m1_req || e1g)       starve = 0;
    else if (starve < STARVE_MAX)    starve++;
    if (rst)      rr_last = 1'b1;
    else if (e0g) rr_last = 1'b0;
    else if (e1g) rr_last = 1'b1;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                       input bit r1, input bit w1i, input logic [31:0] a1, input logic [31:0] d1);
    @(posedge clka); #1;
    m0_req = r0; m0_we = w0;  m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1i; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic idle();
    drive(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = int'($urandom_range(0, 15));
    if (sel == 0)      return (32'($urandom_range(64, 255)) << 2) | 32'($urandom_range(0, 3));
    else if (sel == 1) return $urandom | 32'h8000_0000;
    else               return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  int  cnt;
  bit  got;
  bit  g0, g1;

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      ram[i]  = 32'h1000_0000 + 32'(i);
      gold[i] = 32'h1000_0000 + 32'(i);
    end
    ram[4]  = 32'hA5A5_0001;
    gold[4] = 32'hA5A5_0001;

    // reset: requests are ignored
    drive(1, 0, 32'h10, 32'd0, 1, 0, 32'h14, 32'd0);
    @(negedge clka);
    chk("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    chk("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
    idle();
    @(posedge clka); #1 rst = 1'b0;

    // 1: m0 read 0x10 alone
    drive(1, 0, 32'h10, 32'd0, 0, 0, 32'd0, 32'd0);
    @(negedge clka);
    chk("t1_gnt", {31'd0, m0_gnt}, 32'd1);
    idle();
    @(negedge clka);
    chk("t1_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("t1_rdata", m0_rdata, 32'hA5A5_0001);

    // 3: m1 write 0x20, then m0 reads it back
    drive(0, 0, 32'd0, 32'd0, 1, 1, 32'h20, 32'hDEAD_BEEF);
    @(negedge clka);
    chk("t3_wr_we", {31'd0, mem_we}, 32'd1);
    drive(1, 0, 32'h20, 32'd0, 0, 0, 32'd0, 32'd0);
    @(negedge clka);
    chk("t3_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    idle();
    @(negedge clka);
    chk("t3_rdata", m0_rdata, 32'hDEAD_BEEF);

    // 5: out-of-range m1 write
    drive(0, 0, 32'd0, 32'd0, 1, 1, 32'h100, 32'h1234_5678);
    @(negedge clka);
    chk("t5_gnt", {31'd0, m1_gnt}, 32'd1);
    chk("t5_we", {31'd0, mem_we}, 32'd0);
    drive(1, 0, 32'h0, 32'd0, 0, 0, 32'd0, 32'd0);
    @(negedge clka);
    chk("t5_err", {31'd0, addr_err}, 32'd1);
    idle();
    @(negedge clka);
    chk("t5_err_pulse", {31'd0, addr_err}, 32'd0);
    chk("t5_ram0", m0_rdata, 32'h1000_0000);

    // 4: alternating m0 0x40 / m1 0x44 reads
    drive(1, 0, 32'h40, 32'd0, 0, 0, 32'd0, 32'd0);
    drive(0, 0, 32'd0, 32'd0, 1, 0, 32'h44, 32'd0);
    @(negedge clka);
    chk("t4_m0_data", m0_rdata, 32'h1000_0010);
    drive(1, 0, 32'h40, 32'd0, 0, 0, 32'd0, 32'd0);
    @(negedge clka);
    chk("t4_m1_valid", {31'd0, m1_rvalid}, 32'd1);
    chk("t4_m1_data", m1_rdata, 32'h1000_0011);
    drive(0, 0, 32'd0, 32'd0, 1, 0, 32'h44, 32'd0);
    idle();

    // 2: both read every cycle; count cycles until m1 wins
    drive(1, 0, 32'h40, 32'd0, 1, 0, 32'h44, 32'd0);
    cnt = 0; got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clka);
      if (m1_gnt) begin got = 1'b1; cnt = k; end
      else begin @(posedge clka); #1; end
    end
`ifdef ARB_RR_EN
    chk("t2_m1_win_cycle", 32'(cnt), 32'd2);
`else
    chk("t2_m1_win_cycle", 32'(cnt), 32'd9);
`endif
    @(posedge clka); #1;
    @(negedge clka);
    chk("t2_m0_resumes", {31'd0, m0_gnt}, 32'd1);
    idle();
    idle();

    // 6: reset right after a granted read drops the return
    drive(1, 0, 32'h10, 32'd0, 0, 0, 32'd0, 32'd0);
    @(negedge clka);
    chk("t6_gnt", {31'd0, m0_gnt}, 32'd1);
    @(posedge clka); #1;
    rst = 1'b1; m0_req = 1'b0;
    @(negedge clka);
    chk("t6_rvalid_rst", {31'd0, m0_rvalid}, 32'd0);
    @(posedge clka); #1 rst = 1'b0;
    @(negedge clka);
    chk("t6_rvalid_after", {31'd0, m0_rvalid}, 32'd0);

    // randomized phase; requests held until granted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clka);
      g0 = m0_gnt; g1 = m1_gnt;
      @(posedge clka); #1;
      rst = ($urandom_range(0, 99) == 0);
      if (!m0_req || g0) begin
        m0_req = ($urandom_range(0, 2) != 0); m0_we = 1'($urandom_range(0, 1));
        m0_addr = rand_addr(); m0_wdata = $urandom;
      end
      if (!m1_req || g1) begin
        m1_req = ($urandom_range(0, 2) != 0); m1_we = 1'($urandom_range(0, 1));
        m1_addr = rand_addr(); m1_wdata = $urandom;
      end
    end
    @(posedge clka); #1 rst = 1'b0;
    idle();
    idle();
    @(negedge clka);
    @(posedge clka); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
